// File: rtl/echo_delay_line.sv
// Echo-path delay line: ring buffer in inferred simple dual-port RAM, emits the dry
// sample and the sample from delay_i strobes earlier, two cycles after each strobe.
module echo_delay_line #(
    parameter int DATAW  = 16,
    parameter int AWIDTH = 10
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              sample_valid_i,
    input  logic [DATAW-1:0]  sample_i,
    input  logic [AWIDTH-1:0] delay_i,
    output logic [DATAW-1:0]  dry_o,
    output logic [DATAW-1:0]  wet_o,
    output logic              valid_o
);

    localparam int DEPTH = 2**AWIDTH;
    localparam logic [AWIDTH-1:0] FILL_MAX = AWIDTH'(DEPTH - 1);

    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] fill_cnt;
    logic [AWIDTH-1:0] delay_eff;
    logic [AWIDTH-1:0] rd_addr;

    logic [DATAW-1:0]  mem [DEPTH];
    logic [DATAW-1:0]  ram_q;

    logic              s1_valid;
    logic              s1_empty;
    logic [DATAW-1:0]  s1_sample;

    // A zero delay would alias the write address; treat it as one sample.
    assign delay_eff = (delay_i == '0) ? AWIDTH'(1) : delay_i;
    assign rd_addr   = wr_ptr - delay_eff;

    // RAM contents are deliberately unreset; fill_cnt masks stale data.
    always_ff @(posedge clk_i) begin
        if (sample_valid_i) begin
            mem[wr_ptr] <= sample_i;
            ram_q       <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            s1_valid  <= 1'b0;
            s1_empty  <= 1'b0;
            s1_sample <= '0;
        end else begin
            s1_valid <= sample_valid_i;
            if (sample_valid_i) begin
                s1_sample <= sample_i;
                s1_empty  <= (fill_cnt < delay_eff);
                wr_ptr    <= wr_ptr + AWIDTH'(1);
                if (fill_cnt != FILL_MAX) begin
                    fill_cnt <= fill_cnt + AWIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dry_o   <= '0;
            wet_o   <= '0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= s1_valid;
            if (s1_valid) begin
                dry_o <= s1_sample;
                wet_o <= s1_empty ? '0 : ram_q;
            end
        end
    end

endmodule

// File: tb/tb_echo_delay_line.sv
// Bench for echo_delay_line: a history-queue model checked every cycle against a
// default-size instance and a 16-deep instance, plus literal expected sequences.
module tb_echo_delay_line;

    logic        clk = 1'b0;
    logic        rst_n_i = 1'b1;
    logic        sample_valid_i;
    logic [15:0] sample_i;
    logic [9:0]  delay_i;
    logic [15:0] dry_o, wet_o, dry_s, wet_s;
    logic        valid_o, valid_s;

    always #5 clk = ~clk;

    echo_delay_line dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .sample_valid_i(sample_valid_i),
        .sample_i(sample_i), .delay_i(delay_i),
        .dry_o(dry_o), .wet_o(wet_o), .valid_o(valid_o)
    );

    echo_delay_line #(.DATAW(16), .AWIDTH(4)) dut_s (
        .clk_i(clk), .rst_n_i(rst_n_i), .sample_valid_i(sample_valid_i),
        .sample_i(sample_i), .delay_i(delay_i[3:0]),
        .dry_o(dry_s), .wet_o(wet_s), .valid_o(valid_s)
    );

    typedef struct {
        int          due;
        logic [15:0] dry;
        logic [15:0] wet;
    } exp_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          chk_en = 1'b0;
    exp_t        exp_q[$];
    logic [15:0] hist[$];
    logic [15:0] last_dry = '0;
    logic [15:0] last_wet = '0;
    logic [15:0] got_dry[$], got_wet[$], gs_wet[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: wet is the sample delay_eff strobes back in the post-reset history, else 0.
    task automatic model_push(input logic [15:0] s, input logic [9:0] d);
        int   de;
        exp_t e;
        de = (d == 0) ? 1 : int'(d);
        e.due = cyc + 2;
        e.dry = s;
        e.wet = (hist.size() >= de) ? hist[hist.size() - de] : 16'd0;
        exp_q.push_back(e);
        hist.push_back(s);
    endtask

    task automatic model_clear();
        hist.delete();
        exp_q.delete();
        last_dry = '0;
        last_wet = '0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (!rst_n_i) begin
                chk("rst_valid", valid_o, 0);
                chk("rst_dry", dry_o, 0);
                chk("rst_wet", wet_o, 0);
                chk("rst_valid_s", valid_s, 0);
            end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                chk("valid", valid_o, 1);
                chk("dry", dry_o, exp_q[0].dry);
                chk("wet", wet_o, exp_q[0].wet);
                chk("valid_s", valid_s, 1);
                chk("dry_s", dry_s, exp_q[0].dry);
                chk("wet_s", wet_s, exp_q[0].wet);
                last_dry = exp_q[0].dry;
                last_wet = exp_q[0].wet;
                void'(exp_q.pop_front());
            end else begin
                chk("idle_valid", valid_o, 0);
                chk("hold_dry", dry_o, last_dry);
                chk("hold_wet", wet_o, last_wet);
                chk("idle_valid_s", valid_s, 0);
                chk("hold_wet_s", wet_s, last_wet);
            end
            if (valid_o) begin
                got_dry.push_back(dry_o);
                got_wet.push_back(wet_o);
            end
            if (valid_s) gs_wet.push_back(wet_s);
        end
    end

    task automatic strobe(input logic [15:0] s, input logic [9:0] d);
        @(posedge clk); #1;
        sample_valid_i = 1'b1;
        sample_i = s;
        delay_i = d;
        model_push(s, d);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            sample_valid_i = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        sample_valid_i = 1'b0;
        rst_n_i = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n_i = 1'b1;
    endtask

    task automatic clear_cap();
        got_dry.delete();
        got_wet.delete();
        gs_wet.delete();
    endtask

    task automatic check_wet(input string nm, input logic [15:0] e[$]);
        chk({nm, "_count"}, got_wet.size(), e.size());
        chk({nm, "_count_s"}, gs_wet.size(), e.size());
        for (int i = 0; i < e.size(); i++) begin
            if (i < got_wet.size()) chk(nm, got_wet[i], e[i]);
            if (i < gs_wet.size()) chk({nm, "_s"}, gs_wet[i], e[i]);
        end
    endtask

    logic [15:0] e[$];
    logic [15:0] dense_dry[$], dense_wet[$];

    initial begin
        sample_valid_i = 1'b0;
        sample_i = '0;
        delay_i = '0;
        #2 rst_n_i = 1'b0;
        #2 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n_i = 1'b1;

        // delay 3, samples 1..5
        do_reset(); clear_cap();
        for (int n = 1; n <= 5; n++) strobe(16'(n), 10'd3);
        idle(4);
        e = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd2};
        check_wet("d3_wet", e);
        for (int i = 0; i < 5 && i < got_dry.size(); i++) chk("d3_dry", got_dry[i], 32'(i + 1));

        // delay 0 behaves as delay 1
        do_reset(); clear_cap();
        strobe(16'd10, 10'd0); strobe(16'd20, 10'd0); strobe(16'd30, 10'd0);
        idle(4);
        e = '{16'd0, 16'd10, 16'd20};
        check_wet("d0_wet", e);

        // delay 15 ramp: wraps the 16-deep ring and saturates its fill count
        do_reset(); clear_cap();
        for (int n = 0; n < 40; n++) strobe(16'(n), 10'd15);
        idle(4);
        chk("ramp_count", got_wet.size(), 40);
        for (int n = 0; n < 40; n++) begin
            if (n < got_wet.size()) chk("ramp_wet", got_wet[n], (n < 15) ? 0 : n - 15);
            if (n < gs_wet.size()) chk("ramp_wet_s", gs_wet[n], (n < 15) ? 0 : n - 15);
        end

        // same stream dense then sparse
        do_reset(); clear_cap();
        for (int n = 0; n < 20; n++) strobe(16'(n * 1234 - 9000), 10'd4);
        idle(4);
        dense_dry = got_dry;
        dense_wet = got_wet;
        do_reset(); clear_cap();
        for (int n = 0; n < 20; n++) begin
            strobe(16'(n * 1234 - 9000), 10'd4);
            idle(4);
        end
        idle(4);
        chk("dense_count", dense_wet.size(), 20);
        chk("sparse_count", got_wet.size(), 20);
        for (int n = 0; n < 20; n++) begin
            if (n < got_wet.size() && n < dense_wet.size()) begin
                chk("sparse_vs_dense_wet", got_wet[n], dense_wet[n]);
                chk("sparse_vs_dense_dry", got_dry[n], dense_dry[n]);
            end
        end

        // delay changes
        do_reset(); clear_cap();
        for (int n = 1; n <= 6; n++) strobe(16'(n), 10'd3);
        strobe(16'd7, 10'd1);
        for (int n = 8; n <= 11; n++) strobe(16'(n), 10'd10);
        idle(4);
        e = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd6, 16'd0, 16'd0, 16'd0, 16'd1};
        check_wet("dchg_wet", e);

        // extremes pass bit-exact
        do_reset(); clear_cap();
        strobe(16'h8000, 10'd1); strobe(16'h7fff, 10'd1); strobe(16'h0000, 10'd1);
        idle(4);
        e = '{16'h0000, 16'h8000, 16'h7fff};
        check_wet("ext_wet", e);

        // reset one cycle after a strobe kills it; strobe right at release is accepted
        do_reset(); clear_cap();
        strobe(16'd5, 10'd2);
        @(posedge clk); #1;
        sample_valid_i = 1'b0;
        rst_n_i = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst_n_i = 1'b1;
        sample_valid_i = 1'b1; sample_i = 16'd7; delay_i = 10'd2;
        model_push(16'd7, 10'd2);
        strobe(16'd8, 10'd2); strobe(16'd9, 10'd2);
        idle(4);
        e = '{16'd0, 16'd0, 16'd7};
        check_wet("rst_wet_seq", e);

        chk("model_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
